// File: rtl/npu_requant_o_if.sv
// Purpose: stream, backpressure and table-programming signals of the output requantiser.
// Latency: none, this is wiring only; the pipeline depth belongs to npu_requant_o.
// Backpressure: ready_o is the upstream ready; ready_i is the downstream ready.
//
// Port summary (names keep the requantiser's point of view):
//   cfg_we_i / cfg_ch_i / cfg_scale_i / cfg_shift_i : per-channel scale/shift table write
//   data_i / valid_i / ready_o                      : accumulator beats into the requantiser
//   data_o / sat_o / valid_o / ready_i              : saturated activations out of it
// Modports: master is the side that feeds beats and consumes results; slave is the requantiser.
interface npu_requant_o_if #(
   parameter int M_LEN = 32,
   parameter int O_LEN = 8,
   parameter int N_CH  = 4,
   parameter int SH_W  = 5,
   parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
   logic                      cfg_we_i;
   logic [CH_W-1:0]           cfg_ch_i;
   logic signed [M_LEN-1:0]   cfg_scale_i;
   logic [SH_W-1:0]           cfg_shift_i;

   logic [N_CH*M_LEN-1:0]     data_i;
   logic                      valid_i;
   logic                      ready_o;

   logic [N_CH*O_LEN-1:0]     data_o;
   logic [N_CH-1:0]           sat_o;
   logic                      valid_o;
   logic                      ready_i;

   modport master (
      output cfg_we_i, cfg_ch_i, cfg_scale_i, cfg_shift_i,
      output data_i, valid_i, ready_i,
      input  ready_o, data_o, sat_o, valid_o
   );

   modport slave (
      input  cfg_we_i, cfg_ch_i, cfg_scale_i, cfg_shift_i,
      input  data_i, valid_i, ready_i,
      output ready_o, data_o, sat_o, valid_o
   );
endinterface

// File: rtl/npu_requant_o.sv
// Purpose: per-channel requantiser, acc * Q31 scale >>> (31 + shift), optional round, saturate.
// Latency: 3 cycles from accept to valid_o; 1 beat/clk while the downstream is ready.
// Backpressure: all three stages stall together when valid_o && !ready_i; ready_o = stage enable.
//
// Ports:
//   clk_i  : clock, everything on the rising edge
//   rst_i  : asynchronous active-high reset; clears pipeline, outputs and the table
//   bus    : npu_requant_o_if.slave carrying the table write port, the input
//            beat (data_i/valid_i/ready_o) and the output beat (data_o/sat_o/valid_o/ready_i)
// Build option: define NPU_REQUANT_O_ROUND_EN to add 2^(s-1) before the shift
// (round half toward +inf); leave it undefined for plain truncation toward -inf.
module npu_requant_o #(
   parameter int M_LEN = 32,
   parameter int O_LEN = 8,
   parameter int N_CH  = 4,
   parameter int SH_W  = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   npu_requant_o_if.slave  bus
);
   // Product width, and one extra bit so the rounding add can never overflow.
   localparam int PW  = 2 * M_LEN;
   localparam int RW  = PW + 1;
   // Total shift 31 + shift must be representable (at least 6 bits for 31 + 31).
   localparam int S_W = (SH_W + 1 > 6) ? SH_W + 1 : 6;

   localparam logic signed [RW-1:0] O_MAX = (RW'(1) <<< (O_LEN - 1)) - RW'(1);
   localparam logic signed [RW-1:0] O_MIN = -(RW'(1) <<< (O_LEN - 1));

   logic                    en;
   logic                    accept;

   // Per-channel programming table.
   logic signed [M_LEN-1:0] scale_tab [N_CH];
   logic [SH_W-1:0]         shift_tab [N_CH];

   // Stage registers.
   logic                    v1;
   logic                    v2;
   logic signed [PW-1:0]    p1 [N_CH];
   logic [S_W-1:0]          s1 [N_CH];
   logic signed [RW-1:0]    r2 [N_CH];

   // Combinational next values for each stage.
   logic signed [PW-1:0]    prod  [N_CH];
   logic signed [RW-1:0]    r_nxt [N_CH];
`ifdef NPU_REQUANT_O_ROUND_EN
   logic signed [RW-1:0]    half  [N_CH];
`endif
   logic [N_CH*O_LEN-1:0]   data_nxt;
   logic [N_CH-1:0]         sat_nxt;

   // Bubbles still advance: the pipe only freezes when a valid output is refused.
   assign en          = bus.ready_i || !bus.valid_o;
   assign bus.ready_o = en;
   assign accept      = bus.valid_i && en;

   // Table writes never wait for the pipeline. A beat accepted in the same
   // cycle reads the registered (old) entry, so it keeps the previous scale.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < N_CH; k++) begin
            scale_tab[k] <= '0;
            shift_tab[k] <= '0;
         end
      end else if (bus.cfg_we_i && (int'(bus.cfg_ch_i) < N_CH)) begin
         scale_tab[bus.cfg_ch_i] <= bus.cfg_scale_i;
         shift_tab[bus.cfg_ch_i] <= bus.cfg_shift_i;
      end
   end

   // S1 input: full-precision signed product per channel.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         prod[k] = PW'($signed(bus.data_i[k*M_LEN +: M_LEN])) * PW'(scale_tab[k]);
      end
   end

   // S2 input: arithmetic shift of the product. Shifts past the product width
   // fill with the sign, giving 0 / -1 without any special case.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
`ifdef NPU_REQUANT_O_ROUND_EN
         half[k]  = RW'(1) <<< (s1[k] - S_W'(1));
         r_nxt[k] = (RW'(p1[k]) + half[k]) >>> s1[k];
`else
         r_nxt[k] = RW'(p1[k]) >>> s1[k];
`endif
      end
   end

   // S3 input: clip to the signed activation range and flag clipped channels.
   always_comb begin
      data_nxt = '0;
      sat_nxt  = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r2[k] > O_MAX) begin
            data_nxt[k*O_LEN +: O_LEN] = O_MAX[O_LEN-1:0];
            sat_nxt[k]                 = 1'b1;
         end else if (r2[k] < O_MIN) begin
            data_nxt[k*O_LEN +: O_LEN] = O_MIN[O_LEN-1:0];
            sat_nxt[k]                 = 1'b1;
         end else begin
            data_nxt[k*O_LEN +: O_LEN] = r2[k][O_LEN-1:0];
         end
      end
   end

   // All stages move in lockstep on en; payload registers only load with a valid
   // beat, and the output stage drives zeros for bubbles so data_o is clean.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         bus.valid_o <= 1'b0;
         bus.data_o  <= '0;
         bus.sat_o   <= '0;
         for (int k = 0; k < N_CH; k++) begin
            p1[k] <= '0;
            s1[k] <= '0;
            r2[k] <= '0;
         end
      end else if (en) begin
         v1 <= accept;
         if (accept) begin
            for (int k = 0; k < N_CH; k++) begin
               p1[k] <= prod[k];
               s1[k] <= S_W'(31) + S_W'(shift_tab[k]);
            end
         end
         v2 <= v1;
         if (v1) begin
            for (int k = 0; k < N_CH; k++) begin
               r2[k] <= r_nxt[k];
            end
         end
         bus.valid_o <= v2;
         bus.data_o  <= v2 ? data_nxt : '0;
         bus.sat_o   <= v2 ? sat_nxt : '0;
      end
   end
endmodule

// File: tb/tb_npu_requant_o.sv
// Purpose: directed bench for npu_requant_o with a reference model and a cycle monitor.
// Latency: checks the 3-cycle accept-to-valid path once, then trusts the scoreboard order.
// Backpressure: includes a 5-cycle downstream stall in the middle of an 8-beat stream.
module tb_npu_requant_o;
   localparam int M_LEN = 32;
   localparam int O_LEN = 8;
   localparam int N_CH  = 4;
   localparam int SH_W  = 5;
   localparam int Q     = 1 << 30;

   typedef struct {
      logic [N_CH*O_LEN-1:0] dat;
      logic [N_CH-1:0]       sat;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   npu_requant_o_if #(.M_LEN(M_LEN), .O_LEN(O_LEN), .N_CH(N_CH), .SH_W(SH_W)) bus ();

   npu_requant_o #(.M_LEN(M_LEN), .O_LEN(O_LEN), .N_CH(N_CH), .SH_W(SH_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int    n_vec = 0;
   int    n_err = 0;
   beat_t exp_q [$];
   beat_t obs_q [$];
   int    m_scale [N_CH];
   int    m_shift [N_CH];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: exact integer product, floor division by 2^s, then clamp.
   function automatic beat_t model(input logic [N_CH*M_LEN-1:0] d);
      beat_t  b;
      longint p, r, dv, hi, lo;
      int     s;
      b.dat = '0;
      b.sat = '0;
      hi = (longint'(1) << (O_LEN - 1)) - 1;
      lo = -(longint'(1) << (O_LEN - 1));
      for (int k = 0; k < N_CH; k++) begin
         p = longint'($signed(d[k*M_LEN +: M_LEN])) * longint'(m_scale[k]);
         s = 31 + m_shift[k];
`ifdef NPU_REQUANT_O_ROUND_EN
         if (s < 63) p = p + (longint'(1) << (s - 1));
`endif
         if (s >= 63) begin
            r = (p < 0) ? -1 : 0;
         end else begin
            dv = longint'(1) << s;
            r  = p / dv;
            if ((p % dv != 0) && (p < 0)) r = r - 1;
         end
         if (r > hi) begin
            r = hi;
            b.sat[k] = 1'b1;
         end else if (r < lo) begin
            r = lo;
            b.sat[k] = 1'b1;
         end
         b.dat[k*O_LEN +: O_LEN] = O_LEN'(r);
      end
      return b;
   endfunction

   function automatic logic [N_CH*M_LEN-1:0] in4(input int a, input int b, input int c, input int d);
      return {32'(d), 32'(c), 32'(b), 32'(a)};
   endfunction

   function automatic logic [N_CH*O_LEN-1:0] out4(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   function automatic beat_t get_obs(input int idx);
      beat_t b;
      b.dat = '0;
      b.sat = '0;
      if (idx >= 0 && idx < obs_q.size()) b = obs_q[idx];
      return b;
   endfunction

   // Monitor on the falling edge: scoreboard, stall stability and ready rule.
   logic                  stalled = 1'b0;
   logic [N_CH*O_LEN-1:0] held_dat;
   logic [N_CH-1:0]       held_sat;
   beat_t                 e;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int k = 0; k < N_CH; k++) begin
            m_scale[k] = 0;
            m_shift[k] = 0;
         end
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_valid", 64'(bus.valid_o), 64'(1));
            chk("hold_data", 64'(bus.data_o), 64'(held_dat));
            chk("hold_sat", 64'(bus.sat_o), 64'(held_sat));
         end
         chk("ready_rule", 64'(bus.ready_o), 64'(!(bus.valid_o && !bus.ready_i)));
         // The beat is costed with the table as it was before any same-cycle write.
         if (bus.valid_i && bus.ready_o) exp_q.push_back(model(bus.data_i));
         if (bus.cfg_we_i && int'(bus.cfg_ch_i) < N_CH) begin
            m_scale[bus.cfg_ch_i] = int'(bus.cfg_scale_i);
            m_shift[bus.cfg_ch_i] = int'(bus.cfg_shift_i);
         end
         if (bus.valid_o && bus.ready_i) begin
            chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("data_o", 64'(bus.data_o), 64'(e.dat));
               chk("sat_o", 64'(bus.sat_o), 64'(e.sat));
            end
            obs_q.push_back('{dat: bus.data_o, sat: bus.sat_o});
         end
         stalled  = bus.valid_o && !bus.ready_i;
         held_dat = bus.data_o;
         held_sat = bus.sat_o;
      end
   end

   // All tasks start and return 1 time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input int ch, input int scale, input int shift);
      bus.cfg_we_i    = 1'b1;
      bus.cfg_ch_i    = 2'(ch);
      bus.cfg_scale_i = 32'(scale);
      bus.cfg_shift_i = 5'(shift);
      idle(1);
      bus.cfg_we_i = 1'b0;
   endtask

   task automatic send(input logic [N_CH*M_LEN-1:0] d);
      int n = 0;
      bus.valid_i = 1'b1;
      bus.data_i  = d;
      @(negedge clk);
      while (!bus.ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || bus.valid_o) && n < 200) begin
         idle(1);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int    lat;
      int    base;
      beat_t b0;
      beat_t b1;

      rst             = 1'b1;
      bus.cfg_we_i    = 1'b0;
      bus.cfg_ch_i    = '0;
      bus.cfg_scale_i = '0;
      bus.cfg_shift_i = '0;
      bus.data_i      = '0;
      bus.valid_i     = 1'b0;
      bus.ready_i     = 1'b1;
      idle(3);
      rst = 1'b0;

      // Reset state, first cycle after release.
      chk("rst_valid_o", 64'(bus.valid_o), 64'(0));
      chk("rst_data_o", 64'(bus.data_o), 64'(0));
      chk("rst_sat_o", 64'(bus.sat_o), 64'(0));
      chk("rst_ready_o", 64'(bus.ready_o), 64'(1));

      // Basic scaling by 0.5 and the 3-cycle latency.
      for (int ch = 0; ch < N_CH; ch++) cfg_write(ch, Q, 0);
      send(in4(200, 200, 200, 200));
      lat = 1;
      while (!bus.valid_o && lat < 20) begin
         idle(1);
         lat++;
      end
      chk("latency", 64'(lat), 64'(3));
      wait_drain();
      b0 = get_obs(obs_q.size() - 1);
      chk("t1_data", 64'(b0.dat), 64'(out4(100, 100, 100, 100)));
      chk("t1_sat", 64'(b0.sat), 64'(0));

      // Rounding vs truncation, including p = -2^(s-1) exactly on channel 3.
      send(in4(-3, 3, 0, -1));
      wait_drain();
      b0 = get_obs(obs_q.size() - 1);
`ifdef NPU_REQUANT_O_ROUND_EN
      chk("t2_round", 64'(b0.dat), 64'(out4(-1, 2, 0, 0)));
`else
      chk("t2_trunc", 64'(b0.dat), 64'(out4(-2, 1, 0, -1)));
`endif
      chk("t2_sat", 64'(b0.sat), 64'(0));

      // Saturation both ways, just-inside values, and the largest shift.
      send(in4(1000, -1000, 254, 256));
      cfg_write(0, Q, 3);
      cfg_write(1, Q, 31);
      cfg_write(2, int'(32'h8000_0000), 31);
      send(in4(1000, -1, int'(32'h8000_0000), -256));
      wait_drain();
      b0 = get_obs(obs_q.size() - 2);
      b1 = get_obs(obs_q.size() - 1);
      chk("t3_clip_data", 64'(b0.dat), 64'(out4(127, -128, 127, 127)));
      chk("t3_clip_sat", 64'(b0.sat), 64'(4'b1011));
`ifdef NPU_REQUANT_O_ROUND_EN
      chk("t3_shift_data", 64'(b1.dat), 64'(out4(63, 0, 1, -128)));
`else
      chk("t3_shift_data", 64'(b1.dat), 64'(out4(62, -1, 1, -128)));
`endif
      chk("t3_shift_sat", 64'(b1.sat), 64'(0));
      for (int ch = 0; ch < N_CH; ch++) cfg_write(ch, Q, 0);

      // 8-beat stream with a 5-cycle downstream stall.
      base = obs_q.size();
      fork
         begin
            for (int i = 0; i < 8; i++) send(in4(2 * i, 2 * i, 2 * i, 2 * i));
         end
         begin
            idle(4);
            bus.ready_i = 1'b0;
            @(negedge clk);
            chk("t4_ready_low", 64'(bus.ready_o), 64'(0));
            idle(5);
            bus.ready_i = 1'b1;
         end
      join
      wait_drain();
      chk("t4_count", 64'(obs_q.size() - base), 64'(8));
      for (int i = 0; i < 8; i++) begin
         b0 = get_obs(base + i);
         chk("t4_order", 64'(b0.dat), 64'(out4(i, i, i, i)));
      end

      // Table write racing an accept: beat A keeps the old scale.
      bus.cfg_we_i    = 1'b1;
      bus.cfg_ch_i    = '0;
      bus.cfg_scale_i = 32'(1 << 29);
      bus.cfg_shift_i = '0;
      bus.data_i      = in4(400, 400, 400, 400);
      bus.valid_i     = 1'b1;
      @(negedge clk);
      chk("t5_ready", 64'(bus.ready_o), 64'(1));
      @(posedge clk);
      #1;
      bus.cfg_we_i = 1'b0;
      send(in4(400, 400, 400, 400));
      wait_drain();
      b0 = get_obs(obs_q.size() - 2);
      b1 = get_obs(obs_q.size() - 1);
      // 400 * 0.5 = 200 is beyond int8 and clips; the new 0.25 scale gives 100.
      chk("t5_a_ch0", 64'(b0.dat[7:0]), 64'(8'd127));
      chk("t5_a_sat", 64'(b0.sat), 64'(4'b1111));
      chk("t5_b_ch0", 64'(b1.dat[7:0]), 64'(8'd100));
      chk("t5_b_sat", 64'(b1.sat), 64'(4'b1110));

      // Reset with three beats in flight.
      base = obs_q.size();
      for (int i = 0; i < 3; i++) send(in4(200, 200, 200, 200));
      rst = 1'b1;
      #1;
      chk("t6_valid_now", 64'(bus.valid_o), 64'(0));
      chk("t6_data_now", 64'(bus.data_o), 64'(0));
      idle(2);
      rst = 1'b0;
      chk("t6_ready_after", 64'(bus.ready_o), 64'(1));
      chk("t6_valid_after", 64'(bus.valid_o), 64'(0));
      send(in4(200, 200, 200, 200));
      wait_drain();
      chk("t6_no_stale", 64'(obs_q.size() - base), 64'(1));
      b0 = get_obs(obs_q.size() - 1);
      chk("t6_cleared", 64'(b0.dat), 64'(0));
      for (int ch = 0; ch < N_CH; ch++) cfg_write(ch, Q, 0);
      send(in4(200, 200, 200, 200));
      wait_drain();
      b0 = get_obs(obs_q.size() - 1);
      chk("t6_reprog", 64'(b0.dat), 64'(out4(100, 100, 100, 100)));

      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
